// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO owner and sequencer for the EX-stage multiplier and divider
//
// Purpose:
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. Operands are latched on issue.
//   The block then drives the pipelined multiplier or the iterative divider and
//   holds the pipeline with stallreq. The stall ends with one DONE cycle in which
//   stallreq is low, so the instruction can leave EX.
//
// Parameters:
//   MUL_LAT     cycles from operand presentation to a valid mul_result (1..7)
//
// Optional feature (macro MULDIV_DIV0_FAST_EN):
//   When defined, a DIV/DIVU with a zero divisor bypasses the divider.
//   It completes after one stall cycle with hi=src1 and lo=32'hFFFF_FFFF.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill in-flight op, no HI/LO write
//   op_valid, op, src1, src2 instruction from EX (op: 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO)
//   stallreq                 hold the pipeline
//   hi, lo                   architectural HI/LO
//   mul_signed, mul_ina/inb  multiplier controls and latched operands
//   mul_result               multiplier product
//   div_start, div_signed    divider controls (start held until div_ready)
//   div_op1/op2, div_annul   latched dividend/divisor, abort strobe
//   div_result, div_ready    {remainder, quotient} and its one-cycle valid

module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] MUL_CNT  = 3'(MUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_BUSY,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        sgn_q;

  logic        is_mul;
  logic        is_div;
  logic        div0_fast;
  logic        issue;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  assign is_mul = op_valid & ((op == OP_MULT) | (op == OP_MULTU));
  assign is_div = op_valid & ((op == OP_DIV) | (op == OP_DIVU));
  // Operands are captured only on a real issue out of IDLE; later EX values are frozen copies anyway.
  assign issue  = (state == S_IDLE) & (is_mul | is_div) & ~flush;

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = is_div & (src2 == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  // The units see registered operands so they stay stable while EX is frozen.
  assign mul_ina    = opa_q;
  assign mul_inb    = opb_q;
  assign div_op1    = opa_q;
  assign div_op2    = opb_q;
  assign mul_signed = sgn_q;
  assign div_signed = sgn_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            state_nxt = S_MUL_WAIT;
          end else if (is_div) begin
            state_nxt = div0_fast ? S_DONE : S_DIV_BUSY;
          end
        end
        S_MUL_WAIT: begin
          if (cnt == 3'd1) begin
            state_nxt = S_DONE;
          end
        end
        S_DIV_BUSY: begin
          if (div_ready) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;  // op_valid ignored: same instruction is leaving EX
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: stall/divider handshakes and HI/LO write requests
  always_comb begin
    stallreq  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi;
    lo_d      = lo;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          stallreq = (is_mul | is_div) & ~flush;
          if (op_valid && !flush) begin
            if (op == OP_MTHI) begin
              hi_we = 1'b1;
              hi_d  = src1;
            end else if (op == OP_MTLO) begin
              lo_we = 1'b1;
              lo_d  = src1;
            end else if (div0_fast) begin
              hi_we = 1'b1;
              lo_we = 1'b1;
              hi_d  = src1;
              lo_d  = 32'hFFFF_FFFF;
            end
          end
        end
        S_MUL_WAIT: begin
          stallreq = ~flush;
          if (cnt == 3'd1 && !flush) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_d  = mul_result[63:32];
            lo_d  = mul_result[31:0];
          end
        end
        S_DIV_BUSY: begin
          stallreq  = ~flush;
          // Start drops in the ready cycle so the divider does not relaunch.
          div_start = ~div_ready & ~flush;
          div_annul = flush;
          if (div_ready && !flush) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_d  = div_result[63:32];
            lo_d  = div_result[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 3'd0;
      opa_q <= 32'd0;
      opb_q <= 32'd0;
      sgn_q <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      if (issue) begin
        opa_q <= src1;
        opb_q <= src2;
        sgn_q <= (op == OP_MULT) | (op == OP_DIV);
      end
      if (issue && is_mul) begin
        cnt <= MUL_CNT;
      end else if (state == S_MUL_WAIT) begin
        cnt <= cnt - 3'd1;
      end
      if (hi_we) begin
        hi <= hi_d;
      end
      if (lo_we) begin
        lo <= lo_d;
      end
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the EX-stage multiply/divide resources. Owns the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and latches operands.
- Drives the pipelined multiplier and the iterative divider, and holds the pipeline with stallreq until the result is written to HI/LO.
- Sits beside the ALU in EX; stallreq feeds the stall controller, and hi/lo feed MFHI/MFLO selection.

Parameters:
- MUL_LAT, 2, cycles from multiplier operand presentation to valid mul_result (legal 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the in-flight op; no HI/LO write
- op_valid  in  1  EX holds a valid muldiv instruction
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; others are no-ops
- src1  in  32  rs value
- src2  in  32  rt value
- stallreq  out  1  hold pipeline (Stop=1)
- hi  out  32  HI register
- lo  out  32  LO register
- mul_signed  out  1  to multiplier
- mul_ina  out  32  latched src1
- mul_inb  out  32  latched src2
- mul_result  in  64  multiplier product
- div_start  out  1  divider start, held high until div_ready
- div_signed  out  1  to divider
- div_op1  out  32  latched dividend
- div_op2  out  32  latched divisor
- div_annul  out  1  abort divider
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider result valid (one cycle)

Behaviour:
- Reset: state=IDLE; hi=lo=0; stallreq=0; div_start=0; div_annul=0; mul_signed=0; div_signed=0; mul_ina/mul_inb/div_op1/div_op2=0.
- Operand latch: on issue from IDLE, src1/src2 are registered. mul_in*/div_op* drive the registered copies, so they stay stable while EX is frozen.
- State IDLE:
  - stallreq = op_valid & (op in 0..3) & ~flush, combinational on the issue cycle.
  - MULT/MULTU -> MUL_WAIT; cnt loaded with MUL_LAT.
  - DIV/DIVU -> DIV_BUSY.
  - MTHI/MTLO: hi<=src1 or lo<=src1 at the next edge. No stall, stays IDLE.
- State MUL_WAIT:
  - stallreq=1; cnt decrements each cycle.
  - When cnt==1: {hi,lo}<=mul_result at that edge; -> DONE.
  - MULT latency = MUL_LAT+1 stall cycles.
- State DIV_BUSY:
  - stallreq=1; div_start=1; div_signed held.
  - On the div_ready cycle: hi<=div_result[63:32], lo<=div_result[31:0]; div_start=0 combinationally in that cycle; -> DONE.
- State DONE:
  - stallreq=0 for exactly one cycle, so the pipeline advances the same instruction out of EX.
  - op_valid is ignored this cycle (no reissue); -> IDLE.
- Signedness:
  - MULT/DIV: signed=1; MULTU/DIVU: signed=0.
  - HI=product[63:32] or remainder; LO=product[31:0] or quotient.
- Flush, any state:
  - Next state IDLE; no HI/LO write; stallreq=0 in the flush cycle.
  - div_annul=1 for one cycle if flush arrives in DIV_BUSY.
- rst mid-operation: immediate return to reset values, including hi/lo cleared.
- op_valid with an illegal op (6,7): ignored.
- A new MTHI/MTLO cannot occur while busy, because the pipeline is stalled.

Optional Feature:
- Macro: MULDIV_DIV0_FAST_EN.
- Defined: DIV/DIVU with src2==0 skip the divider. State goes IDLE->DONE with one stall cycle; hi<=src1, lo<=32'hFFFF_FFFF; div_start never asserts.
- Undefined: a zero divisor is issued to the divider like any other value; HI/LO take whatever the divider returns.

Test Plan:
- Reset with op_valid=0 -> hi=lo=0, stallreq=0, div_start=0.
- MULT src1=32'hFFFF_FFFE (-2), src2=3, MUL_LAT=2, multiplier model -> stallreq high 3 cycles, then low 1 cycle; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- DIVU src1=100, src2=7, divider ready after 34 cycles -> div_start high until ready; hi=2, lo=14; single DONE cycle; no reissue while op_valid is still high.
- DIV src1=-7, src2=2 -> hi=32'hFFFF_FFFF (rem -1), lo=32'hFFFF_FFFD (-3); div_signed=1 throughout.
- MTHI src1=32'h1234_5678, then MTLO src1=32'hCAFE_0000 on consecutive cycles -> no stall; hi/lo updated one edge later each.
- DIVU in progress, flush at cycle 5 -> div_annul pulse, stallreq=0, hi/lo unchanged, state IDLE.
- With MULTU_DIV0_FAST_EN replaced by MULDIV_DIV0_FAST_EN defined: DIVU src1=9, src2=0 -> one stall cycle, hi=9, lo=32'hFFFF_FFFF, div_start stays 0.
